// File: rtl/button_event_decoder.sv
// Button event decoder: turns a debounced level into press/release/short/long/double pulses.
// Latency: 1 cycle from sampled level to registered pulse; no backpressure (pulses are unconditional).
module button_event_decoder #(
    parameter int LONG_PERIOD = 1000,
    parameter int DOUBLE_GAP  = 500,
    parameter int CNT_W       = $clog2(((LONG_PERIOD > DOUBLE_GAP) ? LONG_PERIOD : DOUBLE_GAP) + 1)
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    output logic o_press,
    output logic o_release,
    output logic o_short,
    output logic o_long,
    output logic o_double
);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_PRESSED1    = 3'd1,
        S_LONG_HELD   = 3'd2,
        S_WAIT_SECOND = 3'd3,
        S_PRESSED2    = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_PERIOD - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DOUBLE_GAP - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_prev;
    logic             w_rise;

    logic r_press,   w_press_nxt;
    logic r_release, w_release_nxt;
    logic r_short,   w_short_nxt;
    logic r_long,    w_long_nxt;
    logic r_double,  w_double_nxt;

    assign w_rise = i_level & ~r_prev;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_prev    <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_short   <= 1'b0;
            r_long    <= 1'b0;
            r_double  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_prev    <= i_level;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
            r_short   <= w_short_nxt;
            r_long    <= w_long_nxt;
            r_double  <= w_double_nxt;
        end
    end

    // Counter is compared before increment in both timed states, so it never wraps.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_short_nxt   = 1'b0;
        w_long_nxt    = 1'b0;
        w_double_nxt  = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_rise) begin
                    w_press_nxt = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_PRESSED1;
                end
            end
            S_PRESSED1: begin
                if (!i_level) begin
                    w_release_nxt = 1'b1;
                    w_cnt_nxt     = '0;
                    w_state_nxt   = S_WAIT_SECOND;
                end else if (r_cnt == LONG_LAST) begin
                    w_long_nxt  = 1'b1;
                    w_state_nxt = S_LONG_HELD;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_LONG_HELD: begin
                if (!i_level) begin
                    w_release_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            S_WAIT_SECOND: begin
                // A press on the final gap sample wins over the short timeout.
                if (i_level) begin
                    w_press_nxt  = 1'b1;
                    w_double_nxt = 1'b1;
                    w_state_nxt  = S_PRESSED2;
                end else if (r_cnt == GAP_LAST) begin
                    w_short_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_PRESSED2: begin
                if (!i_level) begin
                    w_release_nxt = 1'b1;
                    w_state_nxt   = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_short   = r_short;
    assign o_long    = r_long;
    assign o_double  = r_double;

endmodule

// File: doc/button_event_decoder.md
# button_event_decoder

Classifies a debounced button level into one-cycle event pulses: press, release, short click, long press and double click. Sits directly downstream of the debouncer, taking its clean, clock-synchronous level output. Its pulses feed control logic such as mode selection and menu navigation. All timing is counted in `i_clk` cycles; there is no prescaler.

## Interface
- `LONG_PERIOD`, default 1000: number of consecutive high samples after the press edge that qualify a long press. Must be ≥ 2.
- `DOUBLE_GAP`, default 500: number of samples after release within which a second press counts as a double click. Must be ≥ 1.
- `CNT_W`, default `$clog2(max(LONG_PERIOD, DOUBLE_GAP) + 1)`: shared counter width. Derived; not overridden.

Ports:
- `i_clk`  in  1  system clock; all logic on rising edge.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_level`  in  1  debounced button level, 1 = pressed; synchronous to `i_clk`.
- `o_press`  out  1  one-cycle pulse on every press edge.
- `o_release`  out  1  one-cycle pulse on every release edge.
- `o_short`  out  1  one-cycle pulse when a single click completes with no second press.
- `o_long`  out  1  one-cycle pulse when a press reaches `LONG_PERIOD`.
- `o_double`  out  1  one-cycle pulse on the second press of a double click.

## Operation
- Edge detect uses a registered copy `prev` of `i_level`. A rise is `i_level & ~prev`; a fall is `~i_level & prev`.
- The state machine has five states: `IDLE`, `PRESSED1`, `LONG_HELD`, `WAIT_SECOND`, `PRESSED2`. It uses one counter `cnt` of width `CNT_W`.
- `IDLE`
  - On a rise: `o_press` ← 1, `cnt` ← 0, go to `PRESSED1`.
- `PRESSED1`
  - `i_level` = 0: `o_release` ← 1, `cnt` ← 0, go to `WAIT_SECOND`.
  - Else, if `cnt == LONG_PERIOD-1`: `o_long` ← 1, go to `LONG_HELD`.
  - Otherwise `cnt` ← `cnt` + 1.
- `LONG_HELD`
  - `i_level` = 0: `o_release` ← 1, go to `IDLE`.
  - No `o_short` and no double-click detection follow a long press.
- `WAIT_SECOND`
  - `i_level` = 1: `o_press` ← 1, `o_double` ← 1, go to `PRESSED2`.
  - Else, if `cnt == DOUBLE_GAP-1`: `o_short` ← 1, go to `IDLE`.
  - Otherwise `cnt` ← `cnt` + 1.
- `PRESSED2`
  - `i_level` = 0: `o_release` ← 1, go to `IDLE`.
  - Long-press timing is not applied to the second press.
- All outputs are registered.
  - Each output is 0 in any cycle where its set condition is not met, so every output is a single-cycle pulse.
  - `o_press` and `o_double` coincide on a double click.
  - No other two outputs are ever high in the same cycle.
- The counter never wraps: it is compared for equality before each increment, and the comparison bounds it to at most `max(LONG_PERIOD, DOUBLE_GAP) - 1`.

## Timing
- Reset (`i_rst_n` = 0) takes effect immediately, asynchronously:
  - state ← `IDLE`, `cnt` ← 0, `prev` ← 0.
  - All five outputs ← 0.
- Reset applies mid-operation as well. Any in-progress click is discarded and no event is emitted for it.
- If `i_level` = 1 at reset release, the first clock edge sees a rise and `o_press` pulses.
- Let E be the clock edge at which the rise is sampled. `o_press` is high for the one cycle following E (latency 1 cycle from the sampled level).
- Long press:
  - `o_long` pulses after edge E+`LONG_PERIOD` if `i_level` was sampled high at every edge E+1 … E+`LONG_PERIOD`.
  - If low is sampled at E+`LONG_PERIOD`, the result is a release, not a long press.
- Let R be the edge at which the release is sampled from `PRESSED1`. `o_release` is high in the cycle after R.
- After R:
  - Press sampled at R+k, 1 ≤ k ≤ `DOUBLE_GAP`: double click. At k = `DOUBLE_GAP` the press has priority over the short timeout.
  - No press through R+`DOUBLE_GAP`: `o_short` pulses after R+`DOUBLE_GAP`.
- After `o_short`, the FSM is in `IDLE`. A press sampled at the very next edge is a new first press (`o_press` only).
- Rise and fall cannot occur on the same edge, so there is no simultaneous-event case beyond the double-versus-short boundary above.

## Test plan
Parameters for all scenarios: `LONG_PERIOD` = 8, `DOUBLE_GAP` = 4.
- Short click: high sampled E..E+2, then low.
  - Required: `o_press` after E, `o_release` after E+3, `o_short` after E+7.
  - `o_long` and `o_double` stay 0.
- Long press: high for 20 samples.
  - Required: `o_long` exactly once, after E+8, and `o_release` on the fall.
  - No `o_short`.
- Long boundary:
  - High at E..E+7, low at E+8: `o_release` after E+8, then `o_short` after E+12; no `o_long`.
  - High through E+8: `o_long` after E+8.
- Double click, second press sampled at R+4: `o_press` and `o_double` together after R+4, `o_release` on the second fall, never `o_short`.
- Gap expiry, second press sampled at R+5: `o_short` after R+4, then a plain `o_press` after R+5 with no `o_double`.
- Reset mid-press: assert `i_rst_n` = 0 at E+5 while held, release it with `i_level` = 0.
  - All outputs are 0 during reset.
  - No `o_long`, `o_short` or `o_release` is emitted afterwards.
  - The next press produces a normal `o_press`.
